sga_sensor_scheduler: RTL

- Sequences the two ultrasonic interfaces (left, right) used for hand-gesture steering in Snake Game Arcade.
- Triggers left then right measurements in alternation, with a guard gap between them so echoes do not cross-talk.
- Recovers from lost echoes with a timeout.
- Converts confirmed proximity readings into single-pulse turn commands for the game control unit.

---
 rtl/sga_sensor_scheduler_if.sv | 29 ++
 rtl/sga_sensor_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sga_sensor_scheduler_if.sv
// Purpose: sensor handshake and command bus between the gesture scheduler and its environment.
// Latency: wiring only, no state.
// Backpressure: none; sensors answer through pronto_*, commands are fire-and-forget pulses.
interface sga_sensor_scheduler_if;
  logic        enable;
  logic        medir_esq;
  logic        medir_dir;
  logic        pronto_esq;
  logic        pronto_dir;
  logic [11:0] medida_esq;
  logic [11:0] medida_dir;
  logic        reset_interface;
  logic        cmd_valid;
  logic        cmd_dir;
  logic [1:0]  timeout_flag;
  logic [3:0]  db_estado;

  modport master (
    input  enable, pronto_esq, pronto_dir, medida_esq, medida_dir,
    output medir_esq, medir_dir, reset_interface, cmd_valid, cmd_dir,
           timeout_flag, db_estado
  );

  modport slave (
    output enable, pronto_esq, pronto_dir, medida_esq, medida_dir,
    input  medir_esq, medir_dir, reset_interface, cmd_valid, cmd_dir,
           timeout_flag, db_estado
  );
endinterface

// File: rtl/sga_sensor_scheduler.sv
// Purpose: alternates left/right ultrasonic measurements with guard gaps, recovers lost echoes, emits confirmed turn commands.
// Latency: medir/reset_interface decode the current state; cmd_valid is registered, high the cycle after DECIDE.
// Backpressure: none; a WAIT state gives up after TIMEOUT_CYCLES and pulses reset_interface.
module sga_sensor_scheduler #(
  parameter int unsigned GAP_CYCLES     = 400000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter logic [11:0] NEAR_THRESH    = 12'd10,
  parameter int unsigned CONFIRM        = 2
) (
  input logic                    clock,
  input logic                    reset_n,
  sga_sensor_scheduler_if.master bus
);
  localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       CONF_N    = 3'(CONFIRM);
  localparam logic [11:0]      FAR       = 12'hFFF;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TRIG_ESQ = 4'd1,
    WAIT_ESQ = 4'd2,
    GAP_ESQ  = 4'd3,
    TRIG_DIR = 4'd4,
    WAIT_DIR = 4'd5,
    GAP_DIR  = 4'd6,
    DECIDE   = 4'd7,
    TOUT     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_LEFT  = 2'd1,
    CAND_RIGHT = 2'd2
  } cand_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             tout_side;   // 0: left side timed out, 1: right side
  logic [11:0]      lat_esq, lat_dir;
  logic [1:0]       tflag;
  logic [2:0]       conf_cnt, conf_next;
  cand_t            last_cand, cand;
  logic             armed;
  logic             cmd_valid_q, cmd_dir_q;
  logic             near_e, near_d;
  logic             medir_esq_c, medir_dir_c, reset_if_c;

  // Next-state and state-decoded strobes
  always_comb begin
    state_next  = state;
    medir_esq_c = 1'b0;
    medir_dir_c = 1'b0;
    reset_if_c  = 1'b0;
    case (state)
      IDLE:     if (bus.enable) state_next = TRIG_ESQ;
      TRIG_ESQ: begin
        medir_esq_c = 1'b1;
        state_next  = WAIT_ESQ;
      end
      WAIT_ESQ: begin
        // a pronto coinciding with the last wait cycle still counts as an answer
        if (bus.pronto_esq)       state_next = GAP_ESQ;
        else if (cnt == TOUT_LAST) state_next = TOUT;
      end
      GAP_ESQ:  if (cnt == GAP_LAST) state_next = TRIG_DIR;
      TRIG_DIR: begin
        medir_dir_c = 1'b1;
        state_next  = WAIT_DIR;
      end
      WAIT_DIR: begin
        if (bus.pronto_dir)       state_next = GAP_DIR;
        else if (cnt == TOUT_LAST) state_next = TOUT;
      end
      GAP_DIR:  if (cnt == GAP_LAST) state_next = DECIDE;
      DECIDE:   state_next = bus.enable ? TRIG_ESQ : IDLE;
      TOUT: begin
        reset_if_c = 1'b1;
        state_next = tout_side ? GAP_DIR : GAP_ESQ;
      end
      default:  state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Shared wait/gap counter: restarts on every state change, runs only while waiting or gapping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (state inside {WAIT_ESQ, GAP_ESQ, WAIT_DIR, GAP_DIR}) cnt <= cnt + CNT_W'(1);
  end

  // Distance capture; a lost echo reads as far and raises the sticky per-side flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_esq   <= FAR;
      lat_dir   <= FAR;
      tflag     <= 2'b00;
      tout_side <= 1'b0;
    end else begin
      case (state)
        WAIT_ESQ: begin
          if (bus.pronto_esq) lat_esq <= bus.medida_esq;
          else if (cnt == TOUT_LAST) begin
            lat_esq   <= FAR;
            tflag[0]  <= 1'b1;
            tout_side <= 1'b0;
          end
        end
        WAIT_DIR: begin
          if (bus.pronto_dir) lat_dir <= bus.medida_dir;
          else if (cnt == TOUT_LAST) begin
            lat_dir   <= FAR;
            tflag[1]  <= 1'b1;
            tout_side <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Round candidate and saturating confirmation count
  always_comb begin
    near_e = lat_esq < NEAR_THRESH;
    near_d = lat_dir < NEAR_THRESH;
    cand   = CAND_NONE;
    if (near_e && !near_d)      cand = CAND_LEFT;
    else if (near_d && !near_e) cand = CAND_RIGHT;
    conf_next = 3'd1;
    if (cand == last_cand) conf_next = (conf_cnt >= CONF_N) ? CONF_N : conf_cnt + 3'd1;
  end

  // Decision: one command per held gesture, re-armed only by an empty round
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conf_cnt    <= 3'd0;
      last_cand   <= CAND_NONE;
      armed       <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (state == DECIDE) begin
        last_cand <= cand;
        if (cand == CAND_NONE) begin
          conf_cnt <= 3'd0;
          armed    <= 1'b1;
        end else begin
          conf_cnt <= conf_next;
          if (conf_next == CONF_N && armed) begin
            cmd_valid_q <= 1'b1;
            cmd_dir_q   <= (cand == CAND_RIGHT);
            armed       <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.medir_esq       = medir_esq_c;
  assign bus.medir_dir       = medir_dir_c;
  assign bus.reset_interface = reset_if_c;
  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_dir         = cmd_dir_q;
  assign bus.timeout_flag    = tflag;
  assign bus.db_estado       = state;
endmodule
